// File: rtl/ibex_pkg.sv
// Shared types for the writeback stage: instruction class and the held entry.
package ibex_pkg;

   typedef enum logic [1:0] {
      WB_INSTR_LOAD  = 2'b00,
      WB_INSTR_STORE = 2'b01,
      WB_INSTR_OTHER = 2'b10
   } wb_instr_type_e;

   typedef struct packed {
      logic           valid;
      wb_instr_type_e instr_type;
      logic [31:0]    pc;
      logic           compressed;
      logic           perf;
      logic [4:0]     waddr;
      logic [31:0]    wdata;
      logic           we;
   } wb_entry_t;

endpackage

// File: rtl/ibex_wb_retire_counter.sv
// 64-bit retired-instruction counter, wraps modulo 2^64.
module ibex_wb_retire_counter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   output logic [63:0] count_o
);

   logic [63:0] count_q;

   // Count one per enabled cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (inc_i) begin
         count_q <= count_q + 64'd1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/ibex_wb_pipe.sv
// Single-entry writeback stage: holds one instruction from ID/EX, waits for
// the LSU response on loads/stores, writes the register file, reports hazard,
// forwarding and retire information.
// Optional macro IBEX_WB_RETIRE_CNT_EN adds a 64-bit retire counter port.
module ibex_wb_pipe
   import ibex_pkg::*;
#(
   parameter bit RV32E = 1'b0
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           en_wb_i,
   input  wb_instr_type_e instr_type_wb_i,
   input  logic [31:0]    pc_id_i,
   input  logic           instr_is_compressed_id_i,
   input  logic           instr_perf_count_id_i,
   input  logic [4:0]     rf_waddr_id_i,
   input  logic [31:0]    rf_wdata_id_i,
   input  logic           rf_we_id_i,
   input  logic           lsu_resp_valid_i,
   input  logic           lsu_resp_err_i,
   input  logic           rf_we_lsu_i,
   input  logic [31:0]    rf_wdata_lsu_i,
   output logic           ready_wb_o,
   output logic [4:0]     rf_waddr_wb_o,
   output logic [31:0]    rf_wdata_wb_o,
   output logic           rf_we_wb_o,
   output logic           rf_write_wb_o,
   output logic [31:0]    rf_wdata_fwd_wb_o,
   output logic           outstanding_load_wb_o,
   output logic           outstanding_store_wb_o,
   output logic [31:0]    pc_wb_o,
   output logic           instr_done_wb_o,
   output logic           perf_instr_ret_wb_o,
   output logic           perf_instr_ret_compressed_wb_o
`ifdef IBEX_WB_RETIRE_CNT_EN
   ,
   output logic [63:0]    instr_ret_cnt_o
`endif
);

   wb_entry_t entry_q;
   wb_entry_t entry_d;
   logic      accept;
   logic      wb_done;
   logic      held_load;
   logic      held_store;
   logic      held_other;

   assign held_load  = entry_q.valid & (entry_q.instr_type == WB_INSTR_LOAD);
   assign held_store = entry_q.valid & (entry_q.instr_type == WB_INSTR_STORE);
   assign held_other = entry_q.valid & (entry_q.instr_type == WB_INSTR_OTHER);

   assign wb_done    = held_other | ((held_load | held_store) & lsu_resp_valid_i);
   assign ready_wb_o = ~entry_q.valid | wb_done;
   assign accept     = en_wb_i & ready_wb_o;

   // Assemble the incoming entry from the ID/EX handover.
   always_comb begin
      entry_d            = '0;
      entry_d.valid      = 1'b1;
      entry_d.instr_type = instr_type_wb_i;
      entry_d.pc         = pc_id_i;
      entry_d.compressed = instr_is_compressed_id_i;
      entry_d.perf       = instr_perf_count_id_i;
      entry_d.waddr      = rf_waddr_id_i;
      entry_d.wdata      = rf_wdata_id_i;
      entry_d.we         = rf_we_id_i;
   end

   // Accept overwrites the entry even while the old one completes (no bubble).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         entry_q <= '0;
      end else if (accept) begin
         entry_q <= entry_d;
      end else if (wb_done) begin
         entry_q.valid <= 1'b0;
      end
   end

   // Register-file write strobe and data per held instruction class.
   always_comb begin
      rf_we_wb_o    = 1'b0;
      rf_wdata_wb_o = entry_q.wdata;
      if (held_other) begin
         rf_we_wb_o = entry_q.we;
      end else if (held_load) begin
         rf_we_wb_o    = lsu_resp_valid_i & rf_we_lsu_i & ~lsu_resp_err_i;
         rf_wdata_wb_o = rf_wdata_lsu_i;
      end
   end

   assign rf_waddr_wb_o          = {(RV32E ? 1'b0 : entry_q.waddr[4]), entry_q.waddr[3:0]};
   assign rf_write_wb_o          = entry_q.valid & (entry_q.we | (entry_q.instr_type == WB_INSTR_LOAD));
   assign rf_wdata_fwd_wb_o      = entry_q.wdata;
   assign outstanding_load_wb_o  = held_load;
   assign outstanding_store_wb_o = held_store;
   assign pc_wb_o                = entry_q.pc;
   assign instr_done_wb_o        = wb_done;

   assign perf_instr_ret_wb_o            = wb_done & entry_q.perf &
                                           ~((held_load | held_store) & lsu_resp_err_i);
   assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & entry_q.compressed;

`ifdef IBEX_WB_RETIRE_CNT_EN
   ibex_wb_retire_counter u_retire_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (perf_instr_ret_wb_o),
      .count_o (instr_ret_cnt_o)
   );
`endif

endmodule

// File: tb/tb_ibex_wb_pipe.sv
// Self-checking bench for ibex_wb_pipe: per-cycle vector table plus directed
// sequences for mid-operation reset and (with IBEX_WB_RETIRE_CNT_EN) the
// retire counter.
module tb_ibex_wb_pipe;
   import ibex_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic           en_wb;
   wb_instr_type_e instr_type;
   logic [31:0]    pc_id;
   logic           comp_id;
   logic           perf_id;
   logic [4:0]     waddr_id;
   logic [31:0]    wdata_id;
   logic           we_id;
   logic           resp_valid;
   logic           resp_err;
   logic           we_lsu;
   logic [31:0]    wdata_lsu;

   logic           ready;
   logic [4:0]     waddr_wb;
   logic [31:0]    wdata_wb;
   logic           we_wb;
   logic           write_wb;
   logic [31:0]    fwd_wb;
   logic           out_ld;
   logic           out_st;
   logic [31:0]    pc_wb;
   logic           done_wb;
   logic           ret_wb;
   logic           retc_wb;
`ifdef IBEX_WB_RETIRE_CNT_EN
   logic [63:0]    ret_cnt;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   ibex_wb_pipe #(.RV32E(1'b0)) dut (
      .clk_i                          (clk),
      .rst_i                          (rst),
      .en_wb_i                        (en_wb),
      .instr_type_wb_i                (instr_type),
      .pc_id_i                        (pc_id),
      .instr_is_compressed_id_i       (comp_id),
      .instr_perf_count_id_i          (perf_id),
      .rf_waddr_id_i                  (waddr_id),
      .rf_wdata_id_i                  (wdata_id),
      .rf_we_id_i                     (we_id),
      .lsu_resp_valid_i               (resp_valid),
      .lsu_resp_err_i                 (resp_err),
      .rf_we_lsu_i                    (we_lsu),
      .rf_wdata_lsu_i                 (wdata_lsu),
      .ready_wb_o                     (ready),
      .rf_waddr_wb_o                  (waddr_wb),
      .rf_wdata_wb_o                  (wdata_wb),
      .rf_we_wb_o                     (we_wb),
      .rf_write_wb_o                  (write_wb),
      .rf_wdata_fwd_wb_o              (fwd_wb),
      .outstanding_load_wb_o          (out_ld),
      .outstanding_store_wb_o         (out_st),
      .pc_wb_o                        (pc_wb),
      .instr_done_wb_o                (done_wb),
      .perf_instr_ret_wb_o            (ret_wb),
      .perf_instr_ret_compressed_wb_o (retc_wb)
`ifdef IBEX_WB_RETIRE_CNT_EN
      ,
      .instr_ret_cnt_o                (ret_cnt)
`endif
   );

   typedef struct {
      logic        en;
      logic [1:0]  typ;
      logic [31:0] pc;
      logic        comp;
      logic        perf;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        we;
      logic        rv;
      logic        err;
      logic        we_lsu;
      logic [31:0] ldata;
   } in_t;

   typedef struct {
      logic        ready;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        write;
      logic        ld;
      logic        st;
      logic        done;
      logic        ret;
      logic        retc;
      logic [31:0] pc;
      logic [31:0] fwd;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   localparam logic [1:0] L = 2'd0;
   localparam logic [1:0] S = 2'd1;
   localparam logic [1:0] O = 2'd2;

   function automatic in_t vi(logic en, logic [1:0] typ, logic [31:0] pc, logic comp,
                              logic perf, logic [4:0] waddr, logic [31:0] wdata, logic we,
                              logic rv, logic err, logic wl, logic [31:0] ldata);
      in_t r;
      r.en = en; r.typ = typ; r.pc = pc; r.comp = comp; r.perf = perf;
      r.waddr = waddr; r.wdata = wdata; r.we = we; r.rv = rv; r.err = err;
      r.we_lsu = wl; r.ldata = ldata;
      return r;
   endfunction

   function automatic exp_t ve(logic rdy, logic we, logic [4:0] waddr, logic [31:0] wdata,
                               logic write, logic ld, logic st, logic done, logic ret,
                               logic retc, logic [31:0] pc, logic [31:0] fwd);
      exp_t r;
      r.ready = rdy; r.we = we; r.waddr = waddr; r.wdata = wdata; r.write = write;
      r.ld = ld; r.st = st; r.done = done; r.ret = ret; r.retc = retc; r.pc = pc; r.fwd = fwd;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
      end
   endtask

   task automatic drive(input in_t v);
      en_wb      = v.en;
      instr_type = wb_instr_type_e'(v.typ);
      pc_id      = v.pc;
      comp_id    = v.comp;
      perf_id    = v.perf;
      waddr_id   = v.waddr;
      wdata_id   = v.wdata;
      we_id      = v.we;
      resp_valid = v.rv;
      resp_err   = v.err;
      we_lsu     = v.we_lsu;
      wdata_lsu  = v.ldata;
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, ".ready"}, 64'(ready),    64'(e.ready));
      chk({tag, ".we"},    64'(we_wb),    64'(e.we));
      chk({tag, ".waddr"}, 64'(waddr_wb), 64'(e.waddr));
      chk({tag, ".wdata"}, 64'(wdata_wb), 64'(e.wdata));
      chk({tag, ".write"}, 64'(write_wb), 64'(e.write));
      chk({tag, ".ld"},    64'(out_ld),   64'(e.ld));
      chk({tag, ".st"},    64'(out_st),   64'(e.st));
      chk({tag, ".done"},  64'(done_wb),  64'(e.done));
      chk({tag, ".ret"},   64'(ret_wb),   64'(e.ret));
      chk({tag, ".retc"},  64'(retc_wb),  64'(e.retc));
      chk({tag, ".pc"},    64'(pc_wb),    64'(e.pc));
      chk({tag, ".fwd"},   64'(fwd_wb),   64'(e.fwd));
   endtask

   vec_t vecs[19];
   in_t  idle;
   exp_t zero_e;

   initial begin
      idle   = vi(0, O, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      zero_e = ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Back-to-back ALU ops, then a load held for three cycles.
      vecs[0]  = '{idle, zero_e};
      vecs[1]  = '{vi(1, O, 32'h100, 0, 1, 5, 32'h11, 1, 0, 0, 0, 0), zero_e};
      vecs[2]  = '{vi(1, O, 32'h104, 1, 1, 6, 32'h22, 1, 0, 0, 0, 0),
                   ve(1, 1, 5, 32'h11, 1, 0, 0, 1, 1, 0, 32'h100, 32'h11)};
      vecs[3]  = '{vi(1, O, 32'h106, 0, 1, 7, 32'h33, 1, 0, 0, 0, 0),
                   ve(1, 1, 6, 32'h22, 1, 0, 0, 1, 1, 1, 32'h104, 32'h22)};
      vecs[4]  = '{vi(1, L, 32'h10A, 0, 1, 9, 32'h55, 0, 0, 0, 0, 0),
                   ve(1, 1, 7, 32'h33, 1, 0, 0, 1, 1, 0, 32'h106, 32'h33)};
      vecs[5]  = '{idle, ve(0, 0, 9, 0, 1, 1, 0, 0, 0, 0, 32'h10A, 32'h55)};
      vecs[6]  = '{vi(1, O, 32'h999, 0, 1, 1, 32'h1, 1, 0, 0, 1, 32'h12345678),
                   ve(0, 0, 9, 32'h12345678, 1, 1, 0, 0, 0, 0, 32'h10A, 32'h55)};
      vecs[7]  = '{idle, ve(0, 0, 9, 0, 1, 1, 0, 0, 0, 0, 32'h10A, 32'h55)};
      vecs[8]  = '{vi(0, O, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF),
                   ve(1, 1, 9, 32'hDEADBEEF, 1, 1, 0, 1, 1, 0, 32'h10A, 32'h55)};
      vecs[9]  = '{idle, ve(1, 0, 9, 32'h55, 0, 0, 0, 0, 0, 0, 32'h10A, 32'h55)};
      // Load with bus error.
      vecs[10] = '{vi(1, L, 32'h200, 1, 1, 10, 32'h66, 0, 0, 0, 0, 0),
                   ve(1, 0, 9, 32'h55, 0, 0, 0, 0, 0, 0, 32'h10A, 32'h55)};
      vecs[11] = '{vi(0, O, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'hBAD),
                   ve(1, 0, 10, 32'hBAD, 1, 1, 0, 1, 0, 0, 32'h200, 32'h66)};
      // Store completing while a new ALU op is accepted.
      vecs[12] = '{vi(1, S, 32'h300, 0, 1, 0, 32'h1000, 0, 0, 0, 0, 0),
                   ve(1, 0, 10, 32'h66, 0, 0, 0, 0, 0, 0, 32'h200, 32'h66)};
      vecs[13] = '{idle, ve(0, 0, 0, 32'h1000, 0, 0, 1, 0, 0, 0, 32'h300, 32'h1000)};
      vecs[14] = '{vi(1, O, 32'h304, 1, 1, 3, 32'h44, 1, 1, 0, 1, 32'h77),
                   ve(1, 0, 0, 32'h1000, 0, 0, 1, 1, 1, 0, 32'h300, 32'h1000)};
      // LSU response while holding an ALU op is ignored, error included.
      vecs[15] = '{vi(0, O, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h88),
                   ve(1, 1, 3, 32'h44, 1, 0, 0, 1, 1, 1, 32'h304, 32'h44)};
      vecs[16] = '{idle, ve(1, 0, 3, 32'h44, 0, 0, 0, 0, 0, 0, 32'h304, 32'h44)};
      // Non-counting, non-writing op to x17 (bit 4 kept with RV32E=0).
      vecs[17] = '{vi(1, O, 32'h400, 0, 0, 17, 32'h9, 0, 0, 0, 0, 0),
                   ve(1, 0, 3, 32'h44, 0, 0, 0, 0, 0, 0, 32'h304, 32'h44)};
      vecs[18] = '{idle, ve(1, 0, 17, 32'h9, 0, 0, 0, 1, 0, 0, 32'h400, 32'h9)};

      rst = 1'b1;
      drive(idle);
      repeat (2) @(negedge clk);
      #1;
      check_all("reset", zero_e);
`ifdef IBEX_WB_RETIRE_CNT_EN
      chk("reset.cnt", ret_cnt, 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 19; k++) begin
         @(negedge clk);
         drive(vecs[k].i);
         #1;
         check_all($sformatf("v%0d", k), vecs[k].e);
      end

      // Reset while a load waits: pending entry dropped, late response ignored.
      @(negedge clk);
      drive(vi(1, L, 32'h500, 0, 1, 12, 32'hAB, 0, 0, 0, 0, 0));
      @(negedge clk);
      drive(idle);
      #1;
      chk("rstld.held", 64'(out_ld), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_all("rstld.during", zero_e);
      @(negedge clk);
      rst = 1'b0;
      drive(vi(0, O, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hCAFE));
      #1;
      check_all("rstld.late", zero_e);
      @(negedge clk);
      drive(idle);

`ifdef IBEX_WB_RETIRE_CNT_EN
      begin
         int unsigned cpulses;
         int unsigned rpulses;
         cpulses = 0;
         rpulses = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vi(1, O, 32'h600 + 32'(i * 4), (i == 3 || i == 7), 1, 5'(i + 1), 32'(i), 1,
                     0, 0, 0, 0));
            #1;
            cpulses += 32'(retc_wb);
            rpulses += 32'(ret_wb);
         end
         @(negedge clk);
         drive(idle);
         #1;
         cpulses += 32'(retc_wb);
         rpulses += 32'(ret_wb);
         chk("cnt.before_last", ret_cnt, 64'd9);
         @(negedge clk);
         #1;
         chk("cnt.final", ret_cnt, 64'd10);
         chk("cnt.ret_pulses", 64'(rpulses), 64'd10);
         chk("cnt.comp_pulses", 64'(cpulses), 64'd2);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ibex_wb_pipe.md
# ibex_wb_pipe

Single-entry writeback pipeline stage directly downstream of the ID/EX stage. It captures each instruction that ID/EX hands over, holds loads and stores until the LSU response returns, and performs the final register-file write. It also supplies hazard and forwarding information back to ID and generates retire pulses for the performance counters.

## Interface
Parameters:
- RV32E, 0, when 1 `rf_waddr_wb_o[4]` is forced to 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- en_wb_i  in  1  ID/EX hands over an instruction this cycle
- instr_type_wb_i  in  2  `ibex_pkg::wb_instr_type_e`: WB_INSTR_LOAD / WB_INSTR_STORE / WB_INSTR_OTHER
- pc_id_i  in  32  PC of the handed-over instruction
- instr_is_compressed_id_i  in  1  handed-over instruction is 16-bit
- instr_perf_count_id_i  in  1  instruction counts toward minstret
- rf_waddr_id_i  in  5  destination register
- rf_wdata_id_i  in  32  ALU/CSR result
- rf_we_id_i  in  1  ID-sourced write enable
- lsu_resp_valid_i  in  1  LSU response for the held load or store
- lsu_resp_err_i  in  1  bus error on that response
- rf_we_lsu_i  in  1  load wants to write rd
- rf_wdata_lsu_i  in  32  load data
- ready_wb_o  out  1  stage can accept an instruction this cycle
- rf_waddr_wb_o  out  5  register-file write address
- rf_wdata_wb_o  out  32  register-file write data
- rf_we_wb_o  out  1  register-file write strobe
- rf_write_wb_o  out  1  entry will write rd; ID uses it for hazard detection
- rf_wdata_fwd_wb_o  out  32  forwarding data, ID-sourced results only
- outstanding_load_wb_o  out  1  held entry is a load
- outstanding_store_wb_o  out  1  held entry is a store
- pc_wb_o  out  32  PC of the held entry
- instr_done_wb_o  out  1  held entry completes this cycle
- perf_instr_ret_wb_o  out  1  retire pulse
- perf_instr_ret_compressed_wb_o  out  1  retire pulse, compressed instruction
- instr_ret_cnt_o  out  64  retired-instruction count; present only with IBEX_WB_RETIRE_CNT_EN

## Operation
- Entry fields: valid_q, type_q, pc_q, compressed_q, perf_q, waddr_q, wdata_q, we_q.
- Accept condition: `en_wb_i & ready_wb_o`. On accept, all fields load and valid_q is set to 1.
- `wb_done` = valid_q & (type_q == OTHER | lsu_resp_valid_i).
- `ready_wb_o` = !valid_q | wb_done. Completion and a new accept in the same cycle overwrite the entry; valid_q stays 1 with no bubble.
- If wb_done and no accept, valid_q clears to 0.
- OTHER entries:
  - rf_we_wb_o = we_q.
  - Write data = wdata_q.
- LOAD entries:
  - rf_we_wb_o = lsu_resp_valid_i & rf_we_lsu_i & !lsu_resp_err_i.
  - Write data = rf_wdata_lsu_i.
- STORE entries: never write the register file.
- Bus error: the entry still completes (instr_done_wb_o = 1), performs no register write and raises no retire pulse.
- Hazard and forwarding outputs:
  - rf_write_wb_o = valid_q & (we_q | type_q == LOAD).
  - rf_wdata_fwd_wb_o = wdata_q. Load data is never forwarded; ID stalls on a load.
- outstanding_load_wb_o / outstanding_store_wb_o = valid_q & type matches.
- Retire pulses:
  - perf_instr_ret_wb_o = wb_done & perf_q & !(LSU type & lsu_resp_err_i).
  - perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & compressed_q.
- lsu_resp_valid_i while valid_q = 0, or while type_q = OTHER, is ignored.

## Timing
- Reset value of every output and register is 0; ready_wb_o = 1 during and after reset.
- ID to WB latency is 1 cycle (registered). OTHER entries complete in the first cycle they are held.
- Loads and stores complete in the cycle lsu_resp_valid_i is high. The register write, done and retire outputs are combinational in that same cycle.
- Reset asserted mid-operation drops the pending entry immediately; a late LSU response is then ignored.
- instr_ret_cnt_o updates the cycle after each retire pulse and wraps modulo 2^64.

## Configuration
- IBEX_WB_RETIRE_CNT_EN defined: the 64-bit retire counter and the instr_ret_cnt_o port exist.
- IBEX_WB_RETIRE_CNT_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- `wb_instr_type_e` stays in ibex_pkg.
- Add `wb_entry_t` (a packed struct of the entry fields) to ibex_pkg.
- One natural sub-module: `ibex_wb_retire_counter` (64-bit counter with increment enable), instantiated only under the macro.

## Test plan
- Back-to-back ALU instructions: en_wb_i on 3 consecutive cycles with waddr 5/6/7 and wdata 0x11/0x22/0x33 -> rf_we_wb_o high for 3 cycles with the matching data; ready_wb_o stays 1.
- Load waiting on memory: load to x9 accepted, lsu_resp_valid_i 4 cycles later with data 0xDEADBEEF -> ready_wb_o = 0 for 3 cycles; outstanding_load_wb_o = 1; single write of x9 = 0xDEADBEEF; one retire pulse.
- Load with bus error: lsu_resp_err_i = 1 with the response -> instr_done_wb_o = 1, rf_we_wb_o = 0, perf_instr_ret_wb_o = 0.
- Store completion overlapping a new instruction: store held, response arrives and a new ALU instruction is accepted the same cycle -> valid_q stays 1 and the next cycle writes the new result.
- Reset while a load is pending: rst_i asserted, then lsu_resp_valid_i after release -> no register write; all outputs 0 and ready_wb_o = 1.
- With IBEX_WB_RETIRE_CNT_EN defined: 10 retiring instructions, 2 of them compressed -> instr_ret_cnt_o = 10 one cycle after the last retire; 2 compressed-retire pulses observed.
